d_ff_delay_line: RTL and testbench

Parametrised register delay line with `DEPTH` stages, each `WIDTH` bits wide. It is the generalised successor of the single-bit reset-style flip-flops. Every stage has a clock enable, a synchronous clear and an asynchronous reset, and carries a valid flag alongside its data. A runtime tap select chooses the delay, and registered fill and primed status outputs are provided. It sits between data producers and consumers that need a programmable, stallable latency-matching path.

---
 rtl/d_ff_pkg.sv | 23 ++
 rtl/d_ff_stage.sv | 30 +++
 rtl/d_ff_delay_line.sv | 116 +++++++++++
 tb/tb_d_ff_delay_line.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/d_ff_pkg.sv
// rtl/d_ff_pkg.sv - shared helpers for the d_ff delay line: width derivation and tap clamping
package d_ff_pkg;

    // Bits needed to hold the values 0..n (never less than one bit).
    function automatic int count_width(input int n);
        if (n < 1) begin
            return 1;
        end
        return $clog2(n + 1);
    endfunction

    // Maps a raw tap request onto the legal delay range 1..depth.
    function automatic int clamp_tap(input int tap, input int depth);
        if (tap < 1) begin
            return 1;
        end
        if (tap > depth) begin
            return depth;
        end
        return tap;
    endfunction

endpackage

// File: rtl/d_ff_stage.sv
// rtl/d_ff_stage.sv - one delay-line stage: data plus valid flag with reset, clear and enable
module d_ff_stage #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] d_value,
    input  logic             d_valid,
    output logic [WIDTH-1:0] q_value,
    output logic             q_valid
);

    // Async reset beats sync clear, which beats the shift enable; otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_value <= RESET_VALUE;
            q_valid <= 1'b0;
        end else if (clr) begin
            q_value <= RESET_VALUE;
            q_valid <= 1'b0;
        end else if (en) begin
            q_value <= d_value;
            q_valid <= d_valid;
        end
    end

endmodule

// File: rtl/d_ff_delay_line.sv
// rtl/d_ff_delay_line.sv - stallable delay line with runtime tap select, fill count and primed flag
module d_ff_delay_line
    import d_ff_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter int               DEPTH       = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               TAP_W       = count_width(DEPTH),
    parameter int               FILL_W      = count_width(DEPTH)
) (
    input  logic              i_gated_clock,
    input  logic              i_reset_async,
    input  logic              i_reset_sync,
    input  logic              i_enable,
    input  logic              i_valid,
    input  logic [WIDTH-1:0]  i_value,
    input  logic [TAP_W-1:0]  i_tap,
    output logic [WIDTH-1:0]  o_value,
    output logic              o_valid,
    output logic [FILL_W-1:0] o_fill,
    output logic              o_primed
);

    logic [WIDTH-1:0]  stage_data  [DEPTH];
    logic              stage_valid [DEPTH];
    logic [FILL_W-1:0] shift_count;
    logic [FILL_W-1:0] count_next;
    logic [FILL_W-1:0] fill_next;
    logic              primed_next;
    int                fill_sum;
    int                tap_eff;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic [WIDTH-1:0] d_value;
        logic             d_valid;

        if (k == 0) begin : g_head
            assign d_value = i_value;
            assign d_valid = i_valid;
        end else begin : g_body
            assign d_value = stage_data[k-1];
            assign d_valid = stage_valid[k-1];
        end

        d_ff_stage #(
            .WIDTH       (WIDTH),
            .RESET_VALUE (RESET_VALUE)
        ) u_stage (
            .clk     (i_gated_clock),
            .rst     (i_reset_async),
            .clr     (i_reset_sync),
            .en      (i_enable),
            .d_value (d_value),
            .d_valid (d_valid),
            .q_value (stage_data[k]),
            .q_valid (stage_valid[k])
        );
    end

    // Tap mux reads registers only, so the input never reaches the output combinationally.
    always_comb begin
        tap_eff = clamp_tap(int'(i_tap), DEPTH);
        o_value = stage_data[0];
        o_valid = stage_valid[0];
        for (int k = 0; k < DEPTH; k++) begin
            if (k == tap_eff - 1) begin
                o_value = stage_data[k];
                o_valid = stage_valid[k];
            end
        end
    end

    // Next fill level: one in from the head, one out from the last stage, bounded to 0..DEPTH.
    always_comb begin
        fill_sum = int'(o_fill);
        if (i_valid) begin
            fill_sum = fill_sum + 1;
        end
        if (stage_valid[DEPTH-1]) begin
            fill_sum = fill_sum - 1;
        end
        if (fill_sum < 0) begin
            fill_sum = 0;
        end else if (fill_sum > DEPTH) begin
            fill_sum = DEPTH;
        end
        fill_next = FILL_W'(fill_sum);
    end

    // Saturating shift counter; primed once it has seen DEPTH enabled shifts.
    always_comb begin
        count_next = shift_count;
        if (shift_count != FILL_W'(DEPTH)) begin
            count_next = shift_count + 1'b1;
        end
        primed_next = (count_next == FILL_W'(DEPTH));
    end

    // Status registers follow the same reset/clear/enable priority as the stages.
    always_ff @(posedge i_gated_clock or posedge i_reset_async) begin
        if (i_reset_async) begin
            o_fill      <= '0;
            shift_count <= '0;
            o_primed    <= 1'b0;
        end else if (i_reset_sync) begin
            o_fill      <= '0;
            shift_count <= '0;
            o_primed    <= 1'b0;
        end else if (i_enable) begin
            o_fill      <= fill_next;
            shift_count <= count_next;
            o_primed    <= primed_next;
        end
    end

endmodule

// File: tb/tb_d_ff_delay_line.sv
// tb/tb_d_ff_delay_line.sv - self-checking bench for d_ff_delay_line
module tb_d_ff_delay_line;

    localparam logic [7:0] RV  = 8'hA5;
    localparam logic [7:0] RV1 = 8'h3C;

    logic       clk = 1'b0;
    logic       rst_async;
    logic       rst_sync;
    logic       en;
    logic       valid;
    logic [7:0] value;
    logic [2:0] tap;

    logic [7:0] o_value;
    logic       o_valid;
    logic [2:0] o_fill;
    logic       o_primed;

    logic [7:0] o_value1;
    logic       o_valid1;
    logic [0:0] o_fill1;
    logic       o_primed1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       sync;
        logic       en;
        logic       valid;
        logic [7:0] value;
        logic [2:0] tap;
        logic [7:0] exp_value;
        logic       exp_valid;
        logic [2:0] exp_fill;
        logic       exp_primed;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] sb_q[$];
    logic [7:0] samples[8];

    always #5 clk = ~clk;

    d_ff_delay_line #(
        .WIDTH       (8),
        .DEPTH       (4),
        .RESET_VALUE (RV)
    ) u_dut (
        .i_gated_clock (clk),
        .i_reset_async (rst_async),
        .i_reset_sync  (rst_sync),
        .i_enable      (en),
        .i_valid       (valid),
        .i_value       (value),
        .i_tap         (tap),
        .o_value       (o_value),
        .o_valid       (o_valid),
        .o_fill        (o_fill),
        .o_primed      (o_primed)
    );

    d_ff_delay_line #(
        .WIDTH       (8),
        .DEPTH       (1),
        .RESET_VALUE (RV1)
    ) u_dut1 (
        .i_gated_clock (clk),
        .i_reset_async (rst_async),
        .i_reset_sync  (rst_sync),
        .i_enable      (en),
        .i_valid       (valid),
        .i_value       (value),
        .i_tap         (tap[0:0]),
        .o_value       (o_value1),
        .o_valid       (o_valid1),
        .o_fill        (o_fill1),
        .o_primed      (o_primed1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic s, input logic e, input logic v, input logic [7:0] d,
                       input logic [2:0] t, input logic [7:0] ev, input logic evd,
                       input logic [2:0] ef, input logic ep);
        vec_t r;
        r.sync = s; r.en = e; r.valid = v; r.value = d; r.tap = t;
        r.exp_value = ev; r.exp_valid = evd; r.exp_fill = ef; r.exp_primed = ep;
        vecs.push_back(r);
    endtask

    task automatic check_all(input string tag, input logic [7:0] ev, input logic evd,
                             input logic [2:0] ef, input logic ep);
        check({tag, " value"},  32'(o_value),  32'(ev));
        check({tag, " valid"},  32'(o_valid),  32'(evd));
        check({tag, " fill"},   32'(o_fill),   32'(ef));
        check({tag, " primed"}, 32'(o_primed), 32'(ep));
    endtask

    task automatic sb_pop();
        if (o_valid) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_extra: got valid output %0h, expected none", o_value);
            end else begin
                logic [7:0] exp;
                exp = sb_q.pop_front();
                if (o_value !== exp) begin
                    errors++;
                    $display("FAIL sb_data: got %0h, expected %0h", o_value, exp);
                end
            end
        end
    endtask

    initial begin
        rst_async = 1'b1;
        rst_sync  = 1'b0;
        en        = 1'b0;
        valid     = 1'b0;
        value     = 8'h00;
        tap       = 3'd4;
        #12;
        check_all("reset", RV, 1'b0, 3'd0, 1'b0);
        check("reset dut1 value",  32'(o_value1),  32'(RV1));
        check("reset dut1 primed", 32'(o_primed1), 32'd0);
        @(negedge clk);
        rst_async = 1'b0;

        // sync en val data tap | value valid fill primed
        add(0, 1, 1, 8'h11, 4, RV,    0, 1, 0);
        add(0, 1, 1, 8'h22, 4, RV,    0, 2, 0);
        add(0, 1, 1, 8'h33, 4, RV,    0, 3, 0);
        add(0, 1, 1, 8'h44, 4, 8'h11, 1, 4, 1);
        add(0, 1, 1, 8'h55, 4, 8'h22, 1, 4, 1);
        add(0, 1, 0, 8'h00, 4, 8'h33, 1, 3, 1);
        add(0, 1, 0, 8'h00, 4, 8'h44, 1, 2, 1);
        add(0, 1, 0, 8'h00, 4, 8'h55, 1, 1, 1);
        add(0, 1, 0, 8'h00, 4, 8'h00, 0, 0, 1);
        add(0, 1, 0, 8'h00, 4, 8'h00, 0, 0, 1);
        add(0, 1, 1, 8'hA1, 4, 8'h00, 0, 1, 1);
        add(0, 1, 0, 8'hA2, 4, 8'h00, 0, 1, 1);
        add(0, 1, 1, 8'hA3, 4, 8'h00, 0, 2, 1);
        add(0, 1, 0, 8'hA4, 4, 8'hA1, 1, 2, 1);
        add(0, 1, 0, 8'h00, 4, 8'hA2, 0, 1, 1);
        add(0, 1, 0, 8'h00, 4, 8'hA3, 1, 1, 1);
        add(0, 1, 0, 8'h00, 4, 8'hA4, 0, 0, 1);
        add(0, 1, 0, 8'h00, 4, 8'h00, 0, 0, 1);
        add(0, 1, 1, 8'h01, 4, 8'h00, 0, 1, 1);
        add(0, 1, 1, 8'h02, 4, 8'h00, 0, 2, 1);
        add(0, 1, 1, 8'h03, 4, 8'h00, 0, 3, 1);
        add(0, 1, 1, 8'h04, 4, 8'h01, 1, 4, 1);
        add(0, 0, 1, 8'hFF, 0, 8'h04, 1, 4, 1);
        add(0, 0, 1, 8'hFF, 1, 8'h04, 1, 4, 1);
        add(0, 0, 1, 8'hFF, 2, 8'h03, 1, 4, 1);
        add(0, 0, 1, 8'hFF, 3, 8'h02, 1, 4, 1);
        add(0, 0, 1, 8'hFF, 4, 8'h01, 1, 4, 1);
        add(0, 0, 1, 8'hFF, 7, 8'h01, 1, 4, 1);
        add(0, 0, 1, 8'hFF, 5, 8'h01, 1, 4, 1);
        add(1, 1, 1, 8'h99, 4, RV,    0, 0, 0);
        add(0, 0, 1, 8'hFF, 1, RV,    0, 0, 0);
        add(0, 1, 1, 8'h5A, 4, RV,    0, 1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            rst_sync = vecs[i].sync;
            en       = vecs[i].en;
            valid    = vecs[i].valid;
            value    = vecs[i].value;
            tap      = vecs[i].tap;
            @(posedge clk);
            #1;
            check_all($sformatf("row%0d", i + 1), vecs[i].exp_value, vecs[i].exp_valid,
                      vecs[i].exp_fill, vecs[i].exp_primed);
        end

        // Fill up, then hit the async reset between edges.
        for (int i = 0; i < 3; i++) begin
            en = 1'b1; valid = 1'b1; value = 8'h61 + 8'(i); tap = 3'd4;
            @(posedge clk);
            #1;
        end
        check_all("prefill", 8'h5A, 1'b1, 3'd4, 1'b1);
        #3;
        rst_async = 1'b1;
        #1;
        check_all("async_mid", RV, 1'b0, 3'd0, 1'b0);
        check("async_mid dut1 value",  32'(o_value1),  32'(RV1));
        check("async_mid dut1 primed", 32'(o_primed1), 32'd0);
        tap = 3'd1; en = 1'b1; valid = 1'b1; value = 8'h77;
        @(negedge clk);
        rst_async = 1'b0;
        @(posedge clk);
        #1;
        check_all("after_release", 8'h77, 1'b1, 3'd1, 1'b0);
        check("depth1 value",  32'(o_value1),  32'h77);
        check("depth1 valid",  32'(o_valid1),  32'd1);
        check("depth1 fill",   32'(o_fill1),   32'd1);
        check("depth1 primed", 32'(o_primed1), 32'd1);

        // Stall sequence with scoreboard: clear, one sample, 3 stalled cycles, more samples.
        rst_sync = 1'b1; en = 1'b0; tap = 3'd4;
        @(posedge clk);
        #1;
        rst_sync = 1'b0;
        for (int i = 0; i < 8; i++) begin
            samples[i] = 8'($urandom_range(0, 255));
        end
        begin
            int idx;
            idx = 0;
            for (int c = 1; c <= 11; c++) begin
                en    = !(c >= 2 && c <= 4);
                valid = 1'b1;
                if (en) begin
                    value = samples[idx];
                    sb_q.push_back(samples[idx]);
                    idx++;
                end else begin
                    value = 8'hFF;
                end
                @(posedge clk);
                #1;
                if (c >= 2 && c <= 4) begin
                    check_all($sformatf("stall%0d", c), RV, 1'b0, 3'd1, 1'b0);
                end
                if (c == 6) check("latency_early", 32'(o_valid), 32'd0);
                if (c == 7) check("latency_7", 32'(o_valid), 32'd1);
                sb_pop();
            end
        end
        begin
            int budget;
            budget = 0;
            while (sb_q.size() != 0 && budget < 12) begin
                en = 1'b1; valid = 1'b0; value = 8'h00;
                @(posedge clk);
                #1;
                sb_pop();
                budget++;
            end
        end
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
